// File: rtl/chunked_subtractor_pkg.sv
// chunked_subtractor_pkg: shared state encoding and default geometry for the chunked subtractor.
package chunked_subtractor_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam int WIDTH_DEF = 32;
   localparam int CHUNK_DEF = 4;
   localparam int HALF = WIDTH_DEF / 2;
   localparam int NUM_CHUNKS = HALF / CHUNK_DEF;
   localparam int IDX_W = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [HALF-1:0] UPPER_FILL = '1;
endpackage

// File: rtl/chunked_subtractor_sub_chunk.sv
// chunked_subtractor_sub_chunk: combinational CHUNK-bit subtract-with-borrow cell.
module chunked_subtractor_sub_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             bin,
   output logic [CHUNK-1:0] d,
   output logic             bout
);
   assign {bout, d} = {1'b0, a} - {1'b0, b} - (CHUNK+1)'(bin);
endmodule

// File: rtl/chunked_subtractor.sv
// chunked_subtractor: multi-cycle A - B - bin, CHUNK bits per falling edge, valid/ready on both sides.
module chunked_subtractor
   import chunked_subtractor_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CHUNK = CHUNK_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             bout
);
   localparam int H = WIDTH / 2;
   localparam int N = H / CHUNK;
   localparam int IW = N > 1 ? $clog2(N) : 1;

   if (H % CHUNK != 0) begin : g_chunk_check
      $error("CHUNK must divide WIDTH/2");
   end

   state_t state_q;
   logic [H-1:0] a_q, b_q, d_q;
   logic [IW-1:0] idx_q;
   logic borrow_q, bout_q;
   logic [CHUNK-1:0] d_d;
   logic borrow_d;

   chunked_subtractor_sub_chunk #(.CHUNK(CHUNK)) u_cell (
      .a   (a_q[idx_q*CHUNK +: CHUNK]),
      .b   (b_q[idx_q*CHUNK +: CHUNK]),
      .bin (borrow_q),
      .d   (d_d),
      .bout(borrow_d)
   );

   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign data_out  = {{H{1'b1}}, d_q};
   assign bout      = bout_q;

   always_ff @(negedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         d_q      <= '0;
         idx_q    <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               a_q      <= data_in[H-1:0];
               b_q      <= data_in[WIDTH-1:H];
               borrow_q <= bin;
               d_q      <= '0;
               idx_q    <= '0;
               state_q  <= BUSY;
            end
            BUSY: begin
               d_q[idx_q*CHUNK +: CHUNK] <= d_d;
               borrow_q <= borrow_d;
               idx_q    <= idx_q + 1'b1;
               if (idx_q == IW'(N-1)) begin
                  bout_q  <= borrow_d;
                  state_q <= DONE;
               end
            end
            DONE: if (out_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_chunked_subtractor.sv
// tb_chunked_subtractor: directed vector table, multi-cycle corner sequences and a random regression.
module tb_chunked_subtractor;
   parameter int CHUNK = 4;
   localparam int N = 16 / CHUNK;

   logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, bin = 1'b0, out_ready = 1'b0;
   logic [31:0] data_in = '0;
   logic in_ready, out_valid, bout;
   logic [31:0] data_out;
   int total = 0, bad = 0;

   chunked_subtractor #(.WIDTH(32), .CHUNK(CHUNK)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .data_in(data_in), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .bout(bout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a, b;
      logic        bi;
      logic [15:0] d;
      logic        bo;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                        input logic [15:0] d, input logic bo, input int stall);
      int k;
      k = 0;
      while (!in_ready && k < 50) begin tick(); k++; end
      check("in_ready_before_op", {31'b0, in_ready}, 32'd1);
      data_in = {b, a};
      bin = bi;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 100) begin tick(); k++; end
      check("latency", k, N);
      for (int s = 0; s < stall; s++) tick();
      check("data_out", data_out, {16'hFFFF, d});
      check("bout", {31'b0, bout}, {31'b0, bo});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   vec_t vecs[9];

   initial begin
      int diff, k, seen;
      logic [15:0] ra, rb;
      logic rbi;
      vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0};
      vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
      vecs[2] = '{16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0};
      vecs[3] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1};
      vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0};
      vecs[5] = '{16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0};
      vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
      vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0};
      vecs[8] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0};

      // reset, with upper half all-ones even while held
      repeat (3) tick();
      check("rst_data_out_during", data_out, 32'hFFFF0000);
      rst = 1'b1;
      tick();
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_data_out", data_out, 32'hFFFF0000);
      check("rst_bout", {31'b0, bout}, 32'd0);

      foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].d, vecs[i].bo, i % 3);

      // backpressure with in_valid held high throughout
      data_in = {16'h0001, 16'h0010};
      bin = 1'b0;
      in_valid = 1'b1;
      tick();
      k = 0;
      while (!out_valid && k < 100) begin tick(); k++; end
      check("bp_latency", k, N);
      for (int c = 0; c < 10; c++) begin
         tick();
         check("bp_hold_data", data_out, 32'hFFFF000F);
         check("bp_hold_ready", {30'b0, in_ready, out_valid}, 32'd1);
      end
      data_in = {16'h0003, 16'h0009};
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_back_idle", {30'b0, in_ready, out_valid}, 32'd2);
      tick();
      check("bp_next_accept", {31'b0, in_ready}, 32'd0);
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 100) begin tick(); k++; end
      check("bp_next_data", data_out, 32'hFFFF0006);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // reset on the second BUSY edge discards the operation
      data_in = {16'h0001, 16'hFFFF};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      seen = 0;
      for (int c = 0; c < N + 4; c++) begin
         if (out_valid) seen++;
         tick();
      end
      check("midrst_no_valid", seen, 0);
      check("midrst_data_out", data_out, 32'hFFFF0000);
      check("midrst_bout", {31'b0, bout}, 32'd0);
      check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
      do_op(16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 0);

      // random regression against integer model
      for (int r = 0; r < 1000; r++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rbi = 1'($urandom);
         diff = int'(ra) - int'(rb) - int'(rbi);
         do_op(ra, rb, rbi, diff[15:0], diff < 0, int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
